online_digit_sched: RTL
=======================

Name: online_digit_sched

Overview:
- Controller that sequences the quotient-digit packing datapath (d-register/RAM writer) of the online divider.
- Issues divider step pulses.
- Absorbs the online delay.
- Drives the datapath's enable, refresh, accum (RAM word address), counter and shift_cnt so signed digits are packed UNROLLING per word.
- Flushes the two-stage datapath pipeline at the end of a division, then signals done.

Parameters:
- UNROLLING, 64, digits per RAM word; power of two, ≥4.
- ONLINE_DELAY, 3, divider cycles consumed before the first valid quotient digit.
- ADDR_WIDTH, 7, RAM word address width; ceil(2047/UNROLLING) ≤ 2^ADDR_WIDTH required.

Ports:
- clk  in  1  clock.
- asyn_reset  in  1  reset; synchronous, active-high, sampled on the clk rising edge.
- start  in  1  begin a division; accepted only in IDLE.
- num_digits  in  11  quotient digits to produce; latched on accepted start.
- abort  in  1  synchronous cancel; overrides all states except reset.
- digit_valid  in  1  divider has a quotient digit on d_in this cycle.
- div_step  out  1  advance divider one iteration.
- d_enable  out  1  datapath enable.
- refresh  out  1  datapath word-start (clear and load MSB).
- accum  out  ADDR_WIDTH  datapath RAM word address.
- counter  out  11  digits accepted so far in this division.
- shift_cnt  out  11  left alignment applied by datapath to current word.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky; set on a zero-length request, cleared by the next accepted start.

Behaviour:
- All outputs are registered.
- Reset (asyn_reset=1): state IDLE; all outputs 0. Reset mid-division drops the operation with no done pulse.
- FSM states: IDLE, PRIME, RUN, FLUSH, DONE.
- IDLE:
  - start=1 with num_digits=0: err←1, go to DONE (done pulses, no datapath activity).
  - start=1 with num_digits>0: latch N, err←0, counter←0, accum←0, pos←0, dly←ONLINE_DELAY, busy←1, go to PRIME.
- PRIME: div_step=1 each cycle, d_enable=0. dly decrements; when dly reaches 1 go to RUN. PRIME therefore lasts exactly ONLINE_DELAY cycles; ONLINE_DELAY=0 skips PRIME.
- RUN:
  - div_step=1 while counter<N.
  - Each cycle with digit_valid=1: d_enable=1 in the same registered output cycle; counter+1; refresh=1 iff pos==0.
  - pos advances and wraps at UNROLLING-1. On the wrap, accum+1 and becomes visible with the next digit's refresh.
  - digit_valid=0: d_enable=0, no state change (stall).
  - shift_cnt=0 for every digit of a full word.
  - When counter reaches N, go to FLUSH.
- FLUSH: exactly 2 cycles with d_enable=1, refresh=0, div_step=0; digit_valid ignored.
  - shift_cnt = (UNROLLING - (N mod UNROLLING)) mod UNROLLING, so a partial last word is left-aligned.
  - accum holds the last word index.
- DONE: done=1 for one cycle, busy←0, return to IDLE. accum and counter hold their final values until the next start.
- abort=1 in any non-IDLE state: next cycle IDLE, all outputs except err at reset values, no done.
- Simultaneous events:
  - start with abort in IDLE: abort wins.
  - start while busy: ignored.
- Arithmetic: counter and pos never exceed N and UNROLLING-1; accum never wraps under the ADDR_WIDTH constraint.

Decomposition:
- Shared package online_div_pkg holds:
  - state encoding constants;
  - digit-count width (11);
  - default UNROLLING / ONLINE_DELAY / ADDR_WIDTH values.
- One sub-module, online_word_pos_cnt: pos/accum counter with clear, inc and wrap outputs. The FSM, flush counter and delay counter stay in the top module.

Test Plan:
- Reset held 3 cycles, then released -> all outputs 0, state IDLE; start during reset is ignored.
- start, num_digits=5, digit_valid=1 continuously -> div_step high 3 cycles (PRIME), then 5 d_enable cycles with refresh only on the first, accum=0; then 2 flush cycles with shift_cnt=59; done one cycle later; counter=5.
- num_digits=130, digit_valid toggling 1/0 -> refresh on digits 1, 65 and 129 with accum 0, 1 and 2; d_enable low on every stall; shift_cnt=62 in FLUSH; done; counter=130.
- num_digits=128 -> accum ends at 1, shift_cnt=0 in FLUSH; no refresh is issued for a nonexistent third word.
- num_digits=0 -> done next-but-one cycle, err=1, d_enable never high; a following start with 4 clears err.
- abort asserted at digit 40 of 100 -> IDLE next cycle, busy=0, no done; a new start of 3 completes normally with accum=0.

Source files
------------

// File: rtl/online_div_pkg.sv
// Shared definitions for the online divider quotient-digit packing control.
// Holds the scheduler state encoding, the digit-count width and the default
// geometry (digits per RAM word, online delay, RAM address width).
package online_div_pkg;

  localparam int DIGIT_W          = 11;
  localparam int DEF_UNROLLING    = 64;
  localparam int DEF_ONLINE_DELAY = 3;
  localparam int DEF_ADDR_WIDTH   = 7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRIME = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/online_word_pos_cnt.sv
// Digit position within the current RAM word plus the word index.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   clr        return to position 0 of word 0
//   inc        one digit consumed; position advances, wraps into the next word
//   pos        digit position inside the current word (0..UNROLLING-1)
//   word       index of the word the next digit lands in
//   wrap       combinational: this inc fills the current word
module online_word_pos_cnt
  import online_div_pkg::*;
#(
  parameter int UNROLLING  = DEF_UNROLLING,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         inc,
  output logic [$clog2(UNROLLING)-1:0] pos,
  output logic [ADDR_WIDTH-1:0]        word,
  output logic                         wrap
);

  localparam int POS_W = $clog2(UNROLLING);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(UNROLLING - 1);

  logic [POS_W-1:0]      pos_d, pos_q;
  logic [ADDR_WIDTH-1:0] word_d, word_q;

  assign wrap = inc && (pos_q == POS_MAX);
  assign pos  = pos_q;
  assign word = word_q;

  always_comb begin
    pos_d  = pos_q;
    word_d = word_q;
    if (clr) begin
      pos_d  = '0;
      word_d = '0;
    end else if (inc) begin
      if (wrap) begin
        pos_d  = '0;
        word_d = word_q + ADDR_WIDTH'(1);
      end else begin
        pos_d = pos_q + POS_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q  <= '0;
      word_q <= '0;
    end else begin
      pos_q  <= pos_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/online_digit_sched.sv
// Sequencer for the online divider's quotient-digit packing datapath.
// Issues divider steps, absorbs the online delay, packs UNROLLING signed
// digits per RAM word, flushes the two-stage datapath, then pulses done.
// Ports:
//   clk, asyn_reset            clock, synchronous active-high reset
//   start, num_digits          request a division of num_digits digits
//   abort                      synchronous cancel of a running division
//   digit_valid                divider presents a quotient digit
//   div_step                   advance the divider one iteration
//   d_enable, refresh          datapath enable / word-start
//   accum                      datapath RAM word address
//   counter                    digits accepted so far
//   shift_cnt                  left alignment for the current word
//   busy, done, err            status; err is sticky until next accepted start
//
// state | meaning
// IDLE  | waiting for start
// PRIME | stepping divider through the online delay, no digits yet
// RUN   | accepting digits, packing into words
// FLUSH | two cycles draining the datapath pipeline
// DONE  | one-cycle completion pulse
module online_digit_sched
  import online_div_pkg::*;
#(
  parameter int UNROLLING    = DEF_UNROLLING,
  parameter int ONLINE_DELAY = DEF_ONLINE_DELAY,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  asyn_reset,
  input  logic                  start,
  input  logic [DIGIT_W-1:0]    num_digits,
  input  logic                  abort,
  input  logic                  digit_valid,
  output logic                  div_step,
  output logic                  d_enable,
  output logic                  refresh,
  output logic [ADDR_WIDTH-1:0] accum,
  output logic [DIGIT_W-1:0]    counter,
  output logic [DIGIT_W-1:0]    shift_cnt,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int POS_W = $clog2(UNROLLING);
  localparam logic [POS_W-1:0]   POS_MAX  = POS_W'(UNROLLING - 1);
  localparam logic [DIGIT_W-1:0] DLY_INIT = DIGIT_W'(ONLINE_DELAY);

  state_e                state_d, state_q;
  logic [DIGIT_W-1:0]    n_d, n_q;
  logic [DIGIT_W-1:0]    dly_d, dly_q;
  logic                  flush_d, flush_q;
  logic [DIGIT_W-1:0]    flush_shift_d, flush_shift_q;
  logic                  div_step_d, div_step_q;
  logic                  d_enable_d, d_enable_q;
  logic                  refresh_d, refresh_q;
  logic [ADDR_WIDTH-1:0] accum_d, accum_q;
  logic [DIGIT_W-1:0]    counter_d, counter_q;
  logic [DIGIT_W-1:0]    shift_cnt_d, shift_cnt_q;
  logic                  busy_d, busy_q;
  logic                  done_d, done_q;
  logic                  err_d, err_q;

  logic                  cnt_clr, cnt_inc, wrap;
  logic [POS_W-1:0]      pos;
  logic [ADDR_WIDTH-1:0] word;

  online_word_pos_cnt #(
    .UNROLLING  (UNROLLING),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_pos_cnt (
    .clk  (clk),
    .rst  (asyn_reset),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .pos  (pos),
    .word (word),
    .wrap (wrap)
  );

  always_comb begin
    state_d       = state_q;
    n_d           = n_q;
    dly_d         = dly_q;
    flush_d       = flush_q;
    flush_shift_d = flush_shift_q;
    accum_d       = accum_q;
    counter_d     = counter_q;
    busy_d        = busy_q;
    err_d         = err_q;
    div_step_d    = 1'b0;
    d_enable_d    = 1'b0;
    refresh_d     = 1'b0;
    shift_cnt_d   = '0;
    done_d        = 1'b0;
    cnt_clr       = 1'b0;
    cnt_inc       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          if (num_digits == '0) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            n_d        = num_digits;
            err_d      = 1'b0;
            counter_d  = '0;
            accum_d    = '0;
            cnt_clr    = 1'b1;
            dly_d      = DLY_INIT;
            busy_d     = 1'b1;
            div_step_d = 1'b1;
            state_d    = (ONLINE_DELAY == 0) ? ST_RUN : ST_PRIME;
          end
        end
      end
      ST_PRIME: begin
        div_step_d = 1'b1;
        if (dly_q <= DIGIT_W'(1)) state_d = ST_RUN;
        else                      dly_d   = dly_q - DIGIT_W'(1);
      end
      ST_RUN: begin
        if (digit_valid) begin
          cnt_inc    = 1'b1;
          d_enable_d = 1'b1;
          refresh_d  = (pos == '0);
          accum_d    = word;
          counter_d  = counter_q + DIGIT_W'(1);
          if (counter_d == n_q) begin
            state_d = ST_FLUSH;
            flush_d = 1'b0;
            // Unfilled slots of the last word, so it ends up left-aligned.
            flush_shift_d = wrap ? '0 : DIGIT_W'(POS_MAX - pos);
          end
        end
        div_step_d = (counter_d < n_q);
      end
      ST_FLUSH: begin
        d_enable_d  = 1'b1;
        shift_cnt_d = flush_shift_q;
        if (flush_q) state_d = ST_DONE;
        else         flush_d = 1'b1;
      end
      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort && state_q != ST_IDLE) begin
      state_d     = ST_IDLE;
      div_step_d  = 1'b0;
      d_enable_d  = 1'b0;
      refresh_d   = 1'b0;
      accum_d     = '0;
      counter_d   = '0;
      shift_cnt_d = '0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      cnt_clr     = 1'b1;
      cnt_inc     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (asyn_reset) begin
      state_q       <= ST_IDLE;
      n_q           <= '0;
      dly_q         <= '0;
      flush_q       <= 1'b0;
      flush_shift_q <= '0;
      div_step_q    <= 1'b0;
      d_enable_q    <= 1'b0;
      refresh_q     <= 1'b0;
      accum_q       <= '0;
      counter_q     <= '0;
      shift_cnt_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      dly_q         <= dly_d;
      flush_q       <= flush_d;
      flush_shift_q <= flush_shift_d;
      div_step_q    <= div_step_d;
      d_enable_q    <= d_enable_d;
      refresh_q     <= refresh_d;
      accum_q       <= accum_d;
      counter_q     <= counter_d;
      shift_cnt_q   <= shift_cnt_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign div_step  = div_step_q;
  assign d_enable  = d_enable_q;
  assign refresh   = refresh_q;
  assign accum     = accum_q;
  assign counter   = counter_q;
  assign shift_cnt = shift_cnt_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
